pipereg_stage_skid: RTL and testbench
=====================================

Name: pipereg_stage_skid

Overview:
- Parametrised pipeline stage register replacing the per-stage fixed registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload with a valid/ready handshake on both sides, plus external hold (cache wait) and flush (squash) controls.
- A one-entry skid buffer keeps in_ready registered, so no combinational ready path runs backwards across stages.
- Inserts a configurable bubble pattern when the stage is empty and counts stall cycles for performance analysis.

Parameters:
- WIDTH, 64, payload width in bits (stage struct width via $bits).
- BUBBLE, '0 (WIDTH bits), payload value presented on out_data whenever out_valid=0.
- CNT_W, 32, width of the saturating stall counter.
- SKID_EN, 1, 1 = skid buffer present; 0 = plain register with in_ready = out_ready | !out_valid.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  upstream has a payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage accepts this cycle; in_fire = in_valid & in_ready.
- out_valid  out  1  stage holds a valid payload.
- out_data  out  WIDTH  payload, or BUBBLE when out_valid=0.
- out_ready  in  1  downstream accepts; out_fire = out_valid & out_ready & !hold.
- hold  in  1  freeze the stage (Iwait/Dwait style); no transfer in or out.
- flush  in  1  squash all contents (branch mispredict or exception).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- occupancy  out  2  number of entries held, 0..2.

Behaviour:
- Priority per cycle: reset > flush > hold > handshake.
- Reset (synchronous):
  - main_valid=0, skid_valid=0, so out_valid=0 and out_data=BUBBLE.
  - stall_cnt=0, occupancy=0.
  - in_ready=0 during the reset cycle and 1 on the first cycle after.
- States (SKID_EN=1), encoded by {skid_valid, main_valid}:
  - EMPTY (00): in_ready=1; in_fire -> FULL, main<=in_data.
  - FULL (01), main only:
    - out_fire & in_fire -> FULL, main<=in_data.
    - out_fire only -> EMPTY.
    - in_fire without out_fire -> SKID, skid<=in_data.
    - neither -> stay.
  - SKID (11), both valid: in_ready=0. out_fire -> FULL, main<=skid. Order is preserved, and the skid entry is always older than any new input.
- in_ready = !skid_valid & !reset & !hold & !flush. It depends only on registered state plus local controls, never on out_ready.
- Latency: 1 cycle from in_fire to out_valid when empty; zero-bubble throughput of 1 per cycle when out_ready is held high.
- hold=1:
  - All state frozen: main, skid and valid bits keep their values.
  - in_ready=0; no out_fire.
  - out_valid and out_data keep presenting the current entry.
- flush=1:
  - Next cycle main_valid=0 and skid_valid=0; out_data becomes BUBBLE.
  - in_data arriving in the flush cycle is discarded (in_ready=0 that cycle).
  - flush together with hold: flush wins.
- stall_cnt increments by 1 on any cycle where (out_valid & !out_ready) | hold | (in_valid & !in_ready & !flush).
  - Saturates at all-ones; never wraps.
  - Not cleared by flush, only by reset.
- occupancy = main_valid + skid_valid.
- SKID_EN=0: skid is never used; occupancy is at most 1; in_ready = !reset & !hold & !flush & (out_ready | !main_valid). This combinational ready path is accepted in that mode.
- Payload registers are never reset; only valid bits and counters are. out_data is muxed to BUBBLE combinationally from the valid bit.
- All outputs are glitch-free functions of registered state, except in_ready in SKID_EN=0 mode.

Decomposition:
- Add to package pipes:
  - typedef stage_occ_t (logic [1:0]).
  - localparam STALL_CNT_W = 32.
  - A bubble constant per stage struct (e.g. DECODE_BUBBLE: pc = 64'h8000_0000, is_bubble = 1, ctl.op = UNKNOWN, ctl.alufunc = ALU_UNKNOWN, all other fields zero) for use as the BUBBLE override.
- One natural sub-module: sat_counter (parameter W; ports clk, reset, inc, count), also reusable for other perf counters.
- Per-stage wrappers instantiate pipereg_stage_skid with WIDTH = $bits(stage struct) and cast to and from the struct.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x11 while out_ready=1 -> out_valid=1, out_data=0x11 the next cycle; a stream 0x11,0x12,0x13 emerges on consecutive cycles with no gaps.
2. FULL state holding 0x20, out_ready=0, push 0x21 -> occupancy=2, in_ready=0; raise out_ready -> outputs 0x20 then 0x21 in order; stall_cnt advances by the stalled cycles.
3. hold=1 for 3 cycles with out_valid=1, out_data=0x30 and in_valid=1 -> out_data stays 0x30, in_ready=0, occupancy unchanged, stall_cnt += 3.
4. SKID state plus flush=1 with in_valid=1, in_data=0x40 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 0x40 never appears at the output.
5. flush=1 and hold=1 in the same cycle -> flush wins, stage empty next cycle; reset asserted in SKID state -> out_valid=0 and stall_cnt=0 next cycle.
6. CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15; SKID_EN=0 build repeats scenario 1 and shows in_ready following out_ready combinationally.

Source files
------------

// File: rtl/pipereg_stage_skid_pkg.sv
// Shared pipeline-stage types, widths and per-stage bubble constants.
package pipes;

    // Entry count of a skid stage (0..2).
    typedef logic [1:0] stage_occ_t;

    // Default width of the per-stage stall counters.
    localparam int STALL_CNT_W = 32;

    typedef enum logic [2:0] {
        UNKNOWN = 3'd0,
        OP_ALU  = 3'd1,
        OP_LOAD = 3'd2,
        OP_STORE= 3'd3,
        OP_BR   = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        ALU_UNKNOWN = 3'd0,
        ALU_ADD     = 3'd1,
        ALU_SUB     = 3'd2,
        ALU_AND     = 3'd3,
        ALU_OR      = 3'd4
    } alufunc_t;

    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
        logic     wb_en;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        is_bubble;
        ctl_t        ctl;
    } decode_t;

    // Payload presented by an empty decode stage: reset PC, marked as a bubble.
    localparam decode_t DECODE_BUBBLE = '{
        pc:        64'h0000_0000_8000_0000,
        instr:     32'h0000_0000,
        is_bubble: 1'b1,
        ctl:       '{op: UNKNOWN, alufunc: ALU_UNKNOWN, wb_en: 1'b0}
    };

endpackage : pipes

// File: rtl/pipereg_stage_skid_sat_counter.sv
// Saturating up-counter, usable for any performance event.
module sat_counter
    import pipes::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipereg_stage_skid.sv
// Generic pipeline stage register with one-entry skid buffer, hold/flush
// controls, bubble insertion and a saturating stall counter.
module pipereg_stage_skid
    import pipes::*;
#(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] BUBBLE  = '0,
    parameter int               CNT_W   = STALL_CNT_W,
    parameter bit               SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             hold,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output stage_occ_t       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             stall_s;

    // Ready: from registered skid state when buffered, from out_ready otherwise.
    always_comb begin
        if (SKID_EN) begin
            in_ready = !skid_valid_q && !reset && !hold && !flush;
        end else begin
            in_ready = !reset && !hold && !flush && (out_ready || !main_valid_q);
        end
    end

    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = main_valid_q && out_ready && !hold;

    // Next-state: flush beats hold, hold beats handshake; skid entry is always older.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (hold) begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
        end else begin
            case ({skid_valid_q, main_valid_q})
                2'b00: begin
                    if (in_fire_s) begin
                        main_d       = in_data;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b01: begin
                    if (out_fire_s && in_fire_s) begin
                        main_d = in_data;
                    end else if (out_fire_s) begin
                        main_valid_d = 1'b0;
                    end else if (in_fire_s && SKID_EN) begin
                        skid_d       = in_data;
                        skid_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_fire_s) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Valid bits: the only stage state that reset clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers, deliberately left unreset.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_valid_q ? main_q : BUBBLE;
    assign occupancy = stage_occ_t'({1'b0, main_valid_q}) + stage_occ_t'({1'b0, skid_valid_q});

    assign stall_s = (main_valid_q && !out_ready) || hold || (in_valid && !in_ready && !flush);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_s),
        .count (stall_cnt)
    );

endmodule : pipereg_stage_skid

// File: tb/tb_pipereg_stage_skid.sv
module tb_pipereg_stage_skid;
    import pipes::*;

    localparam int               W   = 8;
    localparam logic [W-1:0]     BUB = 8'hA5;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready, hold, flush;
    logic [W-1:0] in_data;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [31:0]  a_cnt;
    stage_occ_t   a_occ;

    logic         b_in_ready, b_out_valid;
    logic [W-1:0] b_out_data;
    logic [3:0]   b_cnt;
    stage_occ_t   b_occ;

    logic         c_in_valid, c_out_ready;
    logic [W-1:0] c_in_data;
    logic         c_in_ready, c_out_valid;
    logic [W-1:0] c_out_data;
    logic [31:0]  c_cnt;
    stage_occ_t   c_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipereg_stage_skid #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(32), .SKID_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .stall_cnt(a_cnt), .occupancy(a_occ));

    pipereg_stage_skid #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(4), .SKID_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .stall_cnt(b_cnt), .occupancy(b_occ));

    pipereg_stage_skid #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(32), .SKID_EN(1'b0)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_ready(c_out_ready), .hold(hold), .flush(flush),
        .stall_cnt(c_cnt), .occupancy(c_occ));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        hold = 1'b0; flush = 1'b0;
        c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        tick(); tick();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'(BUB));
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Scenario 1: back-to-back stream
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick();
        chk("s1_valid", 64'(a_out_valid), 64'd1);
        chk("s1_d11", 64'(a_out_data), 64'h11);
        in_data = 8'h12; tick();
        chk("s1_d12", 64'(a_out_data), 64'h12);
        in_data = 8'h13; tick();
        chk("s1_d13", 64'(a_out_data), 64'h13);
        in_valid = 1'b0; tick();
        chk("s1_drain_valid", 64'(a_out_valid), 64'd0);
        chk("s1_drain_bubble", 64'(a_out_data), 64'(BUB));
        chk("s1_cnt", 64'(a_cnt), 64'd0);

        // Scenario 2: fill skid, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h20;
        tick();
        chk("s2_full_occ", 64'(a_occ), 64'd1);
        in_data = 8'h21;
        #1;
        chk("s2_full_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("s2_skid_occ", 64'(a_occ), 64'd2);
        chk("s2_skid_in_ready", 64'(a_in_ready), 64'd0);
        chk("s2_skid_head", 64'(a_out_data), 64'h20);
        tick();
        chk("s2_cnt", 64'(a_cnt), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("s2_out_first", 64'(a_out_data), 64'h20);
        tick();
        chk("s2_out_second", 64'(a_out_data), 64'h21);
        chk("s2_occ1", 64'(a_occ), 64'd1);
        tick();
        chk("s2_empty", 64'(a_out_valid), 64'd0);
        chk("s2_cnt_final", 64'(a_cnt), 64'd2);

        // Scenario 3: hold for three cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h30;
        tick();
        hold = 1'b1; in_data = 8'h31;
        #1;
        chk("s3_in_ready", 64'(a_in_ready), 64'd0);
        tick(); tick(); tick();
        chk("s3_data", 64'(a_out_data), 64'h30);
        chk("s3_occ", 64'(a_occ), 64'd1);
        chk("s3_cnt", 64'(a_cnt), 64'd5);
        hold = 1'b0;
        tick();
        chk("s3_skid_occ", 64'(a_occ), 64'd2);
        chk("s3_cnt2", 64'(a_cnt), 64'd6);

        // Scenario 4: flush in SKID state discards incoming data
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h40;
        #1;
        chk("s4_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("s4_valid", 64'(a_out_valid), 64'd0);
        chk("s4_bubble", 64'(a_out_data), 64'(BUB));
        chk("s4_occ", 64'(a_occ), 64'd0);
        tick();
        chk("s4_no40", 64'(a_out_valid), 64'd0);
        chk("s4_cnt_kept", 64'(a_cnt), 64'd7);

        // Scenario 5: flush beats hold, then reset in SKID state
        in_valid = 1'b1; in_data = 8'h50; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; hold = 1'b1; flush = 1'b1;
        tick();
        hold = 1'b0; flush = 1'b0;
        chk("s5_flush_hold_valid", 64'(a_out_valid), 64'd0);
        chk("s5_flush_hold_occ", 64'(a_occ), 64'd0);
        chk("s5_cnt", 64'(a_cnt), 64'd8);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h60;
        tick();
        in_data = 8'h61;
        tick();
        in_valid = 1'b0;
        chk("s5_skid_occ", 64'(a_occ), 64'd2);
        chk("s5_cnt9_b", 64'(b_cnt), 64'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_rst_valid", 64'(a_out_valid), 64'd0);
        chk("s5_rst_cnt", 64'(a_cnt), 64'd0);
        chk("s5_rst_occ", 64'(a_occ), 64'd0);

        // Scenario 6a: saturation of the 4-bit counter
        hold = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("s6_cnt32", 64'(a_cnt), 64'd20);
        chk("s6_cnt4_sat", 64'(b_cnt), 64'd15);
        hold = 1'b0;

        // Scenario 6b: plain register build, combinational ready
        c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = 8'h11;
        #1;
        chk("s6c_ready_empty", 64'(c_in_ready), 64'd1);
        tick();
        chk("s6c_d11", 64'(c_out_data), 64'h11);
        c_in_data = 8'h12; tick();
        chk("s6c_d12", 64'(c_out_data), 64'h12);
        c_in_data = 8'h13; tick();
        chk("s6c_d13", 64'(c_out_data), 64'h13);
        c_out_ready = 1'b0; c_in_data = 8'h14;
        #1;
        chk("s6c_ready_lo", 64'(c_in_ready), 64'd0);
        c_out_ready = 1'b1;
        #1;
        chk("s6c_ready_hi", 64'(c_in_ready), 64'd1);
        c_out_ready = 1'b0;
        tick();
        chk("s6c_held", 64'(c_out_data), 64'h13);
        chk("s6c_occ", 64'(c_occ), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipereg_stage_skid
